audio_wr_packer: RTL and testbench

//  Upstream feeder for the DDR AXI write interconnect (record path).

---
 rtl/audio_ddr_pkg.sv | 25 ++
 rtl/audio_beat_fifo.sv | 81 ++++++++
 rtl/audio_wr_packer.sv | 100 ++++++++++
 tb/tb_audio_wr_packer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_ddr_pkg.sv
// Shared definitions for the DDR audio record path: default geometry,
// record command codes and the FIFO control bundle.
package audio_ddr_pkg;

  localparam int DEF_DQ_WIDTH     = 32;
  localparam int DEF_SAMPLE_WIDTH = 16;
  localparam int BEAT_W           = DEF_DQ_WIDTH * 8;
  localparam int LANES            = BEAT_W / DEF_SAMPLE_WIDTH;

  // Record commands decoded upstream; the packer only sees the resulting
  // record_valid level.
  typedef enum logic [7:0] {
    REC_CMD_RST_ADDR = 8'hA0,
    REC_CMD_START    = 8'hA1,
    REC_CMD_STOP     = 8'hA2
  } rec_cmd_e;

  // Per-cycle request into the beat FIFO.
  typedef struct packed {
    logic push;
    logic pop;
    logic flush;
  } fifo_ctl_t;

endpackage

// File: rtl/audio_beat_fifo.sv
// First-word-fall-through beat FIFO. Register array with combinational read
// at rd_ptr; full/empty come from the fill counter so pointers wrap freely.
module audio_beat_fifo
  import audio_ddr_pkg::*;
#(
  parameter  int W     = BEAT_W,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  fifo_ctl_t     ctl,
  input  logic [W-1:0]  wr_data,
  output logic [W-1:0]  head,
  output logic [CW-1:0] fill_level,
  output logic [CW-1:0] fill_next,
  output logic          overflow,
  output logic          underflow
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_addr;
  logic [CW-1:0] fill_q, fill_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          do_push, do_pop;

  // Next-state: flush rebases everything to empty first, then push/pop apply.
  // A pop frees a slot in the same cycle, so push+pop at full is accepted.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (ctl.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end
    do_pop  = ctl.pop && !ctl.flush && (fill_q != '0);
    do_push = ctl.push && ((fill_d != CW'(DEPTH)) || do_pop);
    if (ctl.pop && !ctl.flush && (fill_q == '0)) udf_d = 1'b1;
    if (ctl.push && !do_push)                    ovf_d = 1'b1;
    wr_addr = wr_ptr_d;
    if (do_pop)  rd_ptr_d = rd_ptr_d + AW'(1);
    if (do_push) wr_ptr_d = wr_ptr_d + AW'(1);
    fill_d = fill_d + CW'(do_push) - CW'(do_pop);
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Beat storage; no reset needed since the head is masked while empty.
  always_ff @(posedge clk) begin
    if (rst && do_push) mem_q[wr_addr] <= wr_data;
  end

  assign head       = (fill_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign fill_level = fill_q;
  assign fill_next  = fill_d;
  assign overflow   = ovf_q;
  assign underflow  = udf_q;

endmodule

// File: rtl/audio_wr_packer.sv
// Record-path feeder for the DDR AXI write interconnect: packs audio samples
// into beats, buffers them in a FWFT FIFO and flags when a burst is ready.
module audio_wr_packer
  import audio_ddr_pkg::*;
#(
  parameter  int DQ_WIDTH     = DEF_DQ_WIDTH,
  parameter  int BURST_LEN    = 16,
  parameter  int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter  int FIFO_DEPTH   = 32,
  parameter  int RDY_THRESH   = 16,
  localparam int BW           = DQ_WIDTH * 8,
  localparam int LN           = BW / SAMPLE_WIDTH,
  localparam int LW           = (LN > 1) ? $clog2(LN) : 1,
  localparam int CW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    record_valid,
  input  logic [SAMPLE_WIDTH-1:0] sample_data,
  input  logic                    sample_valid,
  output logic                    channel1_rready,
  output logic [BW-1:0]           channel1_data,
  input  logic                    channel1_rd_en,
  output logic [CW-1:0]           fill_level,
  output logic                    overflow,
  output logic                    underflow
);

  // Ready never asserts with less than one full burst buffered.
  localparam int THRESH = (RDY_THRESH < BURST_LEN) ? BURST_LEN : RDY_THRESH;

  logic                             rec_prev_q, rec_prev_d;
  logic [LW-1:0]                    lane_cnt_q, lane_cnt_d, lane_base;
  logic [LN-1:0][SAMPLE_WIDTH-1:0]  pack_q, pack_d;
  logic                             rready_q, rready_d;
  logic                             rise, fall, accept, last_lane, push;
  logic [CW-1:0]                    fill_next;
  fifo_ctl_t                        fifo_ctl;

  // Lane control: either record edge restarts packing at lane 0, and the
  // sample arriving on a rising edge is taken as lane 0 of the fresh stream.
  always_comb begin
    rec_prev_d = record_valid;
    rise       = record_valid && !rec_prev_q;
    fall       = !record_valid && rec_prev_q;
    accept     = sample_valid && record_valid;
    lane_base  = (rise || fall) ? '0 : lane_cnt_q;
    last_lane  = (lane_base == LW'(LN - 1));
    push       = accept && last_lane;
    lane_cnt_d = lane_base;
    if (accept) lane_cnt_d = last_lane ? '0 : lane_base + LW'(1);
    fifo_ctl.push  = push;
    fifo_ctl.pop   = channel1_rd_en;
    fifo_ctl.flush = rise;
  end

  // Per-lane capture; the pushed beat includes the sample of this cycle.
  for (genvar i = 0; i < LN; i++) begin : g_lane
    assign pack_d[i] = (accept && (lane_base == LW'(i))) ? sample_data
                     : (rise ? '0 : pack_q[i]);
  end

  // Ready follows the post-edge fill level so it lines up with fill_level.
  always_comb begin
    rready_d = (fill_next >= CW'(THRESH));
  end

  // Packer and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rec_prev_q <= 1'b0;
      lane_cnt_q <= '0;
      pack_q     <= '0;
      rready_q   <= 1'b0;
    end else begin
      rec_prev_q <= rec_prev_d;
      lane_cnt_q <= lane_cnt_d;
      pack_q     <= pack_d;
      rready_q   <= rready_d;
    end
  end

  audio_beat_fifo #(
    .W     (BW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .ctl        (fifo_ctl),
    .wr_data    (pack_d),
    .head       (channel1_data),
    .fill_level (fill_level),
    .fill_next  (fill_next),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  assign channel1_rready = rready_q;

endmodule

// File: tb/tb_audio_wr_packer.sv
// Directed bench for audio_wr_packer: hand sequences for the long fill/drain
// corner cases plus a cycle-vector table for flush, underflow and reset.
module tb_audio_wr_packer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         record_valid = 1'b0;
  logic [15:0]  sample_data = '0;
  logic         sample_valid = 1'b0;
  logic         channel1_rd_en = 1'b0;
  logic         channel1_rready;
  logic [255:0] channel1_data;
  logic [5:0]   fill_level;
  logic         overflow;
  logic         underflow;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic        rec;
    logic        sv;
    logic        rd;
    logic [15:0] smp;
    logic [5:0]  fill;
    logic        rdy;
    logic        ovf;
    logic        udf;
    logic [15:0] lo;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  audio_wr_packer dut (
    .clk             (clk),
    .rst             (rst),
    .record_valid    (record_valid),
    .sample_data     (sample_data),
    .sample_valid    (sample_valid),
    .channel1_rready (channel1_rready),
    .channel1_data   (channel1_data),
    .channel1_rd_en  (channel1_rd_en),
    .fill_level      (fill_level),
    .overflow        (overflow),
    .underflow       (underflow)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v, input logic rd);
    sample_data    = v;
    sample_valid   = 1'b1;
    channel1_rd_en = rd;
    step();
    sample_valid   = 1'b0;
    channel1_rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; record_valid = 1'b0; sample_valid = 1'b0; channel1_rd_en = 1'b0;
    step(); step();
    rst = 1'b1; record_valid = 1'b1;
    step();
  endtask

  function automatic logic [255:0] beat(input logic [15:0] first);
    logic [255:0] b;
    for (int i = 0; i < 16; i++) b[i*16 +: 16] = first + 16'(i);
    return b;
  endfunction

  function automatic vec_t mk(input logic r, input logic rec, input logic sv, input logic rd,
                              input logic [15:0] smp, input logic [5:0] fill,
                              input logic udf, input logic [15:0] lo);
    vec_t v;
    v.rst = r; v.rec = rec; v.sv = sv; v.rd = rd; v.smp = smp;
    v.fill = fill; v.rdy = 1'b0; v.ovf = 1'b0; v.udf = udf; v.lo = lo;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Vector table: empty pop, record toggle clears it, rising-edge sample
    // lands in lane 0, reset mid-beat, fresh beat after reset.
    tbl.push_back(mk(1, 1, 0, 1, 16'h0000, 6'd0, 1, 16'h0000));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 6'd0, 1, 16'h0000));
    tbl.push_back(mk(1, 1, 1, 0, 16'h00AA, 6'd0, 0, 16'h0000));
    for (int i = 1; i <= 15; i++)
      tbl.push_back(mk(1, 1, 1, 0, 16'h00AA + 16'(i), (i == 15) ? 6'd1 : 6'd0, 0,
                       (i == 15) ? 16'h00AA : 16'h0000));
    tbl.push_back(mk(1, 1, 1, 1, 16'h00BB, 6'd0, 0, 16'h0000));
    for (int i = 1; i <= 3; i++)
      tbl.push_back(mk(1, 1, 1, 0, 16'h00BB + 16'(i), 6'd0, 0, 16'h0000));
    tbl.push_back(mk(0, 1, 1, 1, 16'hDEAD, 6'd0, 0, 16'h0000));
    tbl.push_back(mk(1, 1, 1, 0, 16'h0055, 6'd0, 0, 16'h0000));
    for (int i = 1; i <= 15; i++)
      tbl.push_back(mk(1, 1, 1, 0, 16'h0055 + 16'(i), (i == 15) ? 6'd1 : 6'd0, 0,
                       (i == 15) ? 16'h0055 : 16'h0000));

    // 1: reset state, then first beat
    step(); step();
    chk("rst_fill", 256'(fill_level), 256'd0);
    chk("rst_rdy",  256'(channel1_rready), 256'd0);
    chk("rst_data", channel1_data, 256'd0);
    chk("rst_ovf",  256'(overflow), 256'd0);
    chk("rst_udf",  256'(underflow), 256'd0);
    rst = 1'b1; record_valid = 1'b1;
    step();
    for (int n = 1; n <= 16; n++) begin
      send(16'(n), 1'b0);
      if (n == 15) chk("t1_fill15", 256'(fill_level), 256'd0);
    end
    chk("t1_fill",  256'(fill_level), 256'd1);
    chk("t1_lo",    256'(channel1_data[15:0]), 256'h0001);
    chk("t1_hi",    256'(channel1_data[255:240]), 256'h0010);
    chk("t1_beat",  channel1_data, beat(16'h0001));
    chk("t1_rdy",   256'(channel1_rready), 256'd0);

    // 2: sixteen beats raise ready, then drain in order
    do_reset();
    for (int n = 1; n <= 256; n++) begin
      send(16'(n), 1'b0);
      if (n == 240) begin
        chk("t2_fill15", 256'(fill_level), 256'd15);
        chk("t2_rdy15",  256'(channel1_rready), 256'd0);
      end
    end
    chk("t2_fill16", 256'(fill_level), 256'd16);
    chk("t2_rdy16",  256'(channel1_rready), 256'd1);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t2_head%0d", k), channel1_data, beat(16'(16*k + 1)));
      channel1_rd_en = 1'b1;
      step();
      channel1_rd_en = 1'b0;
    end
    chk("t2_fill0", 256'(fill_level), 256'd0);
    chk("t2_rdy0",  256'(channel1_rready), 256'd0);
    chk("t2_data0", channel1_data, 256'd0);
    chk("t2_udf",   256'(underflow), 256'd0);

    // 3: overfill; extra beats dropped, head untouched
    do_reset();
    for (int n = 1; n <= 600; n++) begin
      send(16'(n), 1'b0);
      if (n == 512) begin
        chk("t3_fill512", 256'(fill_level), 256'd32);
        chk("t3_ovf512",  256'(overflow), 256'd0);
        chk("t3_rdy512",  256'(channel1_rready), 256'd1);
      end
    end
    chk("t3_fill", 256'(fill_level), 256'd32);
    chk("t3_ovf",  256'(overflow), 256'd1);
    chk("t3_head", channel1_data, beat(16'h0001));

    // 5: partial beat, record drop keeps FIFO, rise flushes
    for (int n = 601; n <= 607; n++) send(16'(n), 1'b0);
    record_valid = 1'b0;
    step();
    chk("t5_keep_fill", 256'(fill_level), 256'd32);
    chk("t5_keep_ovf",  256'(overflow), 256'd1);
    chk("t5_keep_head", channel1_data, beat(16'h0001));
    record_valid = 1'b1;
    for (int i = 0; i < 16; i++) send(16'h0100 + 16'(i), 1'b0);
    chk("t5_fill", 256'(fill_level), 256'd1);
    chk("t5_ovf",  256'(overflow), 256'd0);
    chk("t5_udf",  256'(underflow), 256'd0);
    chk("t5_rdy",  256'(channel1_rready), 256'd0);
    chk("t5_beat", channel1_data, beat(16'h0100));

    // 4: push and pop together at full
    do_reset();
    for (int n = 1; n <= 527; n++) send(16'(n), 1'b0);
    chk("t4_pre_fill", 256'(fill_level), 256'd32);
    send(16'd528, 1'b1);
    chk("t4_fill", 256'(fill_level), 256'd32);
    chk("t4_ovf",  256'(overflow), 256'd0);
    chk("t4_rdy",  256'(channel1_rready), 256'd1);
    chk("t4_head", channel1_data, beat(16'd17));
    for (int k = 0; k < 31; k++) begin
      channel1_rd_en = 1'b1;
      step();
    end
    channel1_rd_en = 1'b0;
    chk("t4_tail_fill", 256'(fill_level), 256'd1);
    chk("t4_tail_beat", channel1_data, beat(16'd513));

    // 6: cycle-vector table
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      rst            = tbl[i].rst;
      record_valid   = tbl[i].rec;
      sample_valid   = tbl[i].sv;
      channel1_rd_en = tbl[i].rd;
      sample_data    = tbl[i].smp;
      step();
      chk($sformatf("v%0d_fill", i), 256'(fill_level), 256'(tbl[i].fill));
      chk($sformatf("v%0d_rdy", i),  256'(channel1_rready), 256'(tbl[i].rdy));
      chk($sformatf("v%0d_ovf", i),  256'(overflow), 256'(tbl[i].ovf));
      chk($sformatf("v%0d_udf", i),  256'(underflow), 256'(tbl[i].udf));
      chk($sformatf("v%0d_lo", i),   256'(channel1_data[15:0]), 256'(tbl[i].lo));
    end
    sample_valid = 1'b0;
    channel1_rd_en = 1'b0;
    chk("t6_final_beat", channel1_data, beat(16'h0055));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
